// File: rtl/bus_pkg.sv
`default_nettype none
//==========================================================================
// bus_pkg -- SoC address map and shared types for the simple 32-bit bus.
// Rev 1.0
//==========================================================================
package bus_pkg;

   localparam int NSLV_DEF = 4;

   // Index order: S0 SRAM, S1 UART, S2 SNN CSR, S3 DMA (S3 overlaps S1, S1 wins)
   localparam logic [NSLV_DEF-1:0][31:0] SLV_BASE_DEF = {
      32'h4000_0000, 32'h4000_1000, 32'h4000_0000, 32'h0000_0000
   };
   localparam logic [NSLV_DEF-1:0][31:0] SLV_MASK_DEF = {
      32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000
   };

   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

   typedef logic [$clog2(NSLV_DEF)-1:0] slv_sel_t;

endpackage
`default_nettype wire

// File: rtl/bus_simple_if.sv
`default_nettype none
//==========================================================================
// bus_simple_if -- simple 32-bit memory-mapped request/response bus.
// Rev 1.0
//==========================================================================
interface bus_simple_if;
   logic        valid;
   logic        write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output valid, write, addr, wdata, wstrb,
                   input  ready, rvalid, rdata);
   modport slave  (input  valid, write, addr, wdata, wstrb,
                   output ready, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/bus_addr_decode.sv
`default_nettype none
//==========================================================================
// bus_addr_decode -- window match per slave, lowest-index priority winner.
// Rev 1.0
//==========================================================================
module bus_addr_decode #(
   parameter int                         NSLV     = 4,
   parameter int                         SEL_W    = 2,
   parameter logic [NSLV-1:0][31:0]      SLV_BASE = '0,
   parameter logic [NSLV-1:0][31:0]      SLV_MASK = '0
) (
   input  logic [31:0]      addr,
   input  logic             valid,
   output logic [NSLV-1:0]  hit,
   output logic [SEL_W-1:0] winner,
   output logic             miss
);

   for (genvar i = 0; i < NSLV; i++) begin : g_hit
      assign hit[i] = (addr & SLV_MASK[i]) == SLV_BASE[i];
   end

   // Scan downward so the lowest matching index is the last assignment.
   always_comb begin
      winner = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (hit[i]) winner = SEL_W'(i);
      end
   end

   assign miss = valid & ~|hit;

endmodule
`default_nettype wire

// File: rtl/bus_interconnect.sv
`default_nettype none
//==========================================================================
// bus_interconnect -- 1-master/NSLV-slave decode, 1-cycle response routing,
// default slave for unmapped accesses and sticky error logging.  Rev 1.0
//==========================================================================
module bus_interconnect
   import bus_pkg::*;
#(
   parameter int                    NSLV      = NSLV_DEF,
   parameter logic [NSLV-1:0][31:0] SLV_BASE  = SLV_BASE_DEF,
   parameter logic [NSLV-1:0][31:0] SLV_MASK  = SLV_MASK_DEF,
   parameter logic [31:0]           ERR_RDATA = ERR_RDATA_DEF,
   parameter int                    CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bus_simple_if.slave          m,
   output logic [NSLV-1:0]      s_valid,
   output logic                 s_write,
   output logic [31:0]          s_addr,
   output logic [31:0]          s_wdata,
   output logic [3:0]           s_wstrb,
   input  logic [NSLV-1:0]      s_ready,
   input  logic [NSLV*32-1:0]   s_rdata,
   input  logic [NSLV-1:0]      s_rvalid,
   input  logic                 err_clr,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 dec_err,
   output logic                 proto_err
);

   localparam int              SEL_W   = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NSLV-1:0]  hit;
   logic [SEL_W-1:0] winner;
   logic             miss;

   logic             pend_q;
   logic             wr_q;
   logic [SEL_W-1:0] sel_q;
   logic             err_q;

   logic             new_err;
   logic             slv_missed;

   bus_addr_decode #(
      .NSLV     (NSLV),
      .SEL_W    (SEL_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_decode (
      .addr   (m.addr),
      .valid  (m.valid),
      .hit    (hit),
      .winner (winner),
      .miss   (miss)
   );

   assign s_write = m.write;
   assign s_addr  = m.addr;
   assign s_wdata = m.wdata;
   assign s_wstrb = m.wstrb;

   always_comb begin
      s_valid = '0;
      if (m.valid && !rst && (|hit)) s_valid[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         wr_q   <= 1'b0;
         sel_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= m.valid;
         wr_q   <= m.write;
         sel_q  <= winner;
         err_q  <= miss;
      end
   end

   // Responses are gated by rst so a pending transfer is dropped immediately.
   always_comb begin
      m.ready  = 1'b0;
      m.rvalid = 1'b0;
      m.rdata  = 32'h0;
      if (pend_q && !rst) begin
         if (err_q) begin
            if (wr_q) begin
               m.ready = 1'b1;
            end else begin
               m.rvalid = 1'b1;
               m.rdata  = ERR_RDATA;
            end
         end else if (wr_q) begin
            m.ready = s_ready[sel_q];
         end else begin
            m.rvalid = s_rvalid[sel_q];
            m.rdata  = s_rdata[32*sel_q +: 32];
         end
      end
   end

   assign new_err    = miss && !rst;
   assign slv_missed = pend_q && !err_q &&
                       !(wr_q ? s_ready[sel_q] : s_rvalid[sel_q]);

   // A new error event takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt   <= '0;
         dec_err   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (new_err) begin
            err_cnt <= err_clr ? CNT_W'(1) :
                       (err_cnt == CNT_MAX) ? CNT_MAX : err_cnt + CNT_W'(1);
            dec_err <= 1'b1;
         end else if (err_clr) begin
            err_cnt <= '0;
            dec_err <= 1'b0;
         end
         if (slv_missed)   proto_err <= 1'b1;
         else if (err_clr) proto_err <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
//==========================================================================
// tb_bus_interconnect -- directed and randomized checks of bus_interconnect.
// Rev 1.0
//==========================================================================
module tb_bus_interconnect;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   s_valid;
   logic         s_write;
   logic [31:0]  s_addr, s_wdata;
   logic [3:0]   s_wstrb;
   logic [3:0]   s_ready, s_rvalid;
   logic [127:0] s_rdata;
   logic         err_clr;
   logic [7:0]   err_cnt;
   logic         dec_err, proto_err;
   logic [31:0]  srd [4];

   int errors = 0;
   int checks = 0;

   // reference model state
   bit          mp_pend = 0, mp_wr = 0;
   int          mp_sel  = -1;
   int          m_cnt   = 0;
   bit          m_dec = 0, m_proto = 0;
   logic [3:0]  exp_svalid;
   logic        exp_ready, exp_rvalid, exp_rd_chk;
   logic [31:0] exp_rdata;

   bus_simple_if m_if ();

   assign s_rdata = {srd[3], srd[2], srd[1], srd[0]};

   bus_interconnect dut (
      .clk       (clk),
      .rst       (rst),
      .m         (m_if),
      .s_valid   (s_valid),
      .s_write   (s_write),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_ready   (s_ready),
      .s_rdata   (s_rdata),
      .s_rvalid  (s_rvalid),
      .err_clr   (err_clr),
      .err_cnt   (err_cnt),
      .dec_err   (dec_err),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   // Address map from the SoC definition; -1 means unmapped.
   function automatic int win_of(input logic [31:0] a);
      if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
      if ((a & 32'hFFFF_F000) == 32'h4000_0000) return 1;
      if ((a & 32'hFFFF_F000) == 32'h4000_1000) return 2;
      if ((a & 32'hFFFF_0000) == 32'h4000_0000) return 3;
      return -1;
   endfunction

   // Drive one cycle of stimulus and compute the expected combinational outputs.
   task automatic apply(input bit v, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [3:0] rdy, input logic [3:0] rv, input bit clr);
      int w;
      @(negedge clk);
      m_if.valid = v; m_if.write = wr; m_if.addr = a; m_if.wdata = wd; m_if.wstrb = st;
      s_ready = rdy; s_rvalid = rv; err_clr = clr;
      w = win_of(a);
      exp_svalid = (v && !rst && w >= 0) ? (4'(1) << w) : 4'h0;
      exp_ready = 1'b0; exp_rvalid = 1'b0; exp_rdata = 32'h0;
      if (mp_pend && !rst) begin
         if (mp_sel < 0) begin
            if (mp_wr) exp_ready = 1'b1;
            else begin exp_rvalid = 1'b1; exp_rdata = 32'hDEAD_BEEF; end
         end else if (mp_wr) begin
            exp_ready = rdy[mp_sel];
         end else begin
            exp_rvalid = rv[mp_sel];
            exp_rdata  = srd[mp_sel];
         end
      end
      exp_rd_chk = !(mp_pend && mp_wr && !rst);
      #1;
   endtask

   // Clock edge: advance the reference model with what was driven this cycle.
   task automatic advance();
      bit new_err, missed;
      @(posedge clk);
      if (rst) begin
         mp_pend = 0; mp_wr = 0; mp_sel = -1; m_cnt = 0; m_dec = 0; m_proto = 0;
      end else begin
         new_err = m_if.valid && (win_of(m_if.addr) < 0);
         missed  = mp_pend && (mp_sel >= 0) &&
                   !(mp_wr ? s_ready[mp_sel] : s_rvalid[mp_sel]);
         if (new_err) begin
            m_cnt = err_clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
            m_dec = 1;
         end else if (err_clr) begin
            m_cnt = 0; m_dec = 0;
         end
         if (missed) m_proto = 1;
         else if (err_clr) m_proto = 0;
         mp_pend = m_if.valid;
         mp_wr   = m_if.write;
         mp_sel  = win_of(m_if.addr);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      advance();
      apply(1, 0, 32'h10, 0, 4'hF, 4'hF, 4'hF, 0);
      checks++; if (s_valid !== 4'h0) begin errors++; $display("FAIL reset_svalid: got %h expected 0", s_valid); end
      checks++; if (m_if.ready !== 1'b0 || m_if.rvalid !== 1'b0 || m_if.rdata !== 32'h0) begin
         errors++; $display("FAIL reset_resp: got ready=%b rvalid=%b rdata=%h expected 0/0/0", m_if.ready, m_if.rvalid, m_if.rdata); end
      advance();
      checks++; if (err_cnt !== 8'd0 || dec_err !== 1'b0 || proto_err !== 1'b0) begin
         errors++; $display("FAIL reset_err: got cnt=%0d dec=%b proto=%b expected 0/0/0", err_cnt, dec_err, proto_err); end
      rst = 1'b0;
   endtask

   task automatic test_write_s2();
      apply(1, 1, 32'h4000_1004, 32'hA5A5_A5A5, 4'hF, 0, 0, 0);
      checks++; if (s_valid !== 4'b0100) begin errors++; $display("FAIL wr_s2_svalid: got %b expected 0100", s_valid); end
      checks++; if (s_write !== 1'b1 || s_addr !== 32'h4000_1004 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'hF) begin
         errors++; $display("FAIL wr_s2_fwd: got w=%b a=%h d=%h s=%h", s_write, s_addr, s_wdata, s_wstrb); end
      checks++; if (m_if.ready !== 1'b0) begin errors++; $display("FAIL wr_s2_early_ready: got %b expected 0", m_if.ready); end
      advance();
      apply(0, 0, 0, 0, 0, 4'b0100, 0, 0);
      checks++; if (m_if.ready !== 1'b1 || m_if.rvalid !== 1'b0) begin
         errors++; $display("FAIL wr_s2_resp: got ready=%b rvalid=%b expected 1/0", m_if.ready, m_if.rvalid); end
      advance();
   endtask

   task automatic test_read_s0();
      srd[0] = 32'h1234_5678;
      apply(1, 0, 32'h0000_0010, 0, 4'hF, 0, 0, 0);
      checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL rd_s0_svalid: got %b expected 0001", s_valid); end
      advance();
      apply(0, 0, 0, 0, 0, 0, 4'b0001, 0);
      checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'h1234_5678 || m_if.ready !== 1'b0) begin
         errors++; $display("FAIL rd_s0_resp: got rvalid=%b rdata=%h ready=%b expected 1/12345678/0", m_if.rvalid, m_if.rdata, m_if.ready); end
      advance();
   endtask

   task automatic test_overlap();
      apply(1, 0, 32'h4000_0008, 0, 4'hF, 0, 0, 0);
      checks++; if (s_valid !== 4'b0010) begin errors++; $display("FAIL overlap_svalid: got %b expected 0010", s_valid); end
      advance();
      srd[1] = 32'hCAFE_0001; srd[3] = 32'hBAD0_0003;
      apply(0, 0, 0, 0, 0, 0, 4'b1010, 0);
      checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hCAFE_0001) begin
         errors++; $display("FAIL overlap_resp: got rvalid=%b rdata=%h expected 1/cafe0001", m_if.rvalid, m_if.rdata); end
      advance();
   endtask

   task automatic test_unmapped();
      apply(1, 0, 32'h8000_0000, 0, 4'hF, 0, 0, 0);
      checks++; if (s_valid !== 4'h0) begin errors++; $display("FAIL unmap_svalid: got %b expected 0000", s_valid); end
      advance();
      checks++; if (err_cnt !== 8'd1 || dec_err !== 1'b1) begin
         errors++; $display("FAIL unmap_err: got cnt=%0d dec=%b expected 1/1", err_cnt, dec_err); end
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hDEAD_BEEF || m_if.ready !== 1'b0) begin
         errors++; $display("FAIL unmap_resp: got rvalid=%b rdata=%h ready=%b expected 1/deadbeef/0", m_if.rvalid, m_if.rdata, m_if.ready); end
      advance();
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL unmap_proto: got %b expected 0", proto_err); end
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      advance();
      checks++; if (err_cnt !== 8'd0 || dec_err !== 1'b0) begin
         errors++; $display("FAIL unmap_clr: got cnt=%0d dec=%b expected 0/0", err_cnt, dec_err); end
   endtask

   task automatic test_back_to_back();
      apply(1, 1, 32'h0000_0100, 32'h1111_1111, 4'hF, 0, 0, 0);
      checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL b2b_c1_svalid: got %b expected 0001", s_valid); end
      advance();
      apply(1, 0, 32'h4000_1010, 0, 4'hF, 4'b0001, 0, 0);
      checks++; if (m_if.ready !== 1'b1 || m_if.rvalid !== 1'b0 || s_valid !== 4'b0100) begin
         errors++; $display("FAIL b2b_c2: got ready=%b rvalid=%b svalid=%b expected 1/0/0100", m_if.ready, m_if.rvalid, s_valid); end
      advance();
      srd[2] = 32'h2222_3333;
      apply(1, 0, 32'h9000_0000, 0, 4'hF, 0, 4'b0100, 0);
      checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'h2222_3333 || s_valid !== 4'h0) begin
         errors++; $display("FAIL b2b_c3: got rvalid=%b rdata=%h svalid=%b expected 1/22223333/0000", m_if.rvalid, m_if.rdata, s_valid); end
      advance();
      apply(1, 1, 32'h4000_0020, 32'h0, 4'hF, 0, 0, 0);
      checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hDEAD_BEEF || m_if.ready !== 1'b0 || s_valid !== 4'b0010) begin
         errors++; $display("FAIL b2b_c4: got rvalid=%b rdata=%h ready=%b svalid=%b", m_if.rvalid, m_if.rdata, m_if.ready, s_valid); end
      advance();
      apply(0, 0, 0, 0, 0, 4'b1101, 4'b1111, 0);
      checks++; if (m_if.ready !== 1'b0 || m_if.rvalid !== 1'b0) begin
         errors++; $display("FAIL b2b_silent: got ready=%b rvalid=%b expected 0/0", m_if.ready, m_if.rvalid); end
      advance();
      checks++; if (proto_err !== 1'b1 || err_cnt !== 8'd1) begin
         errors++; $display("FAIL b2b_proto: got proto=%b cnt=%0d expected 1/1", proto_err, err_cnt); end
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      advance();
      checks++; if (proto_err !== 1'b0 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL b2b_clr: got proto=%b cnt=%0d expected 0/0", proto_err, err_cnt); end
   endtask

   task automatic test_reset_mid();
      srd[0] = 32'h55AA_55AA;
      apply(1, 0, 32'h0000_0020, 0, 4'hF, 0, 0, 0);
      advance();
      rst = 1'b1;
      apply(1, 0, 32'h0000_0030, 0, 4'hF, 4'hF, 4'hF, 0);
      checks++; if (m_if.rvalid !== 1'b0 || m_if.rdata !== 32'h0 || s_valid !== 4'h0) begin
         errors++; $display("FAIL rstmid_during: got rvalid=%b rdata=%h svalid=%b expected 0/0/0", m_if.rvalid, m_if.rdata, s_valid); end
      advance();
      rst = 1'b0;
      apply(0, 0, 0, 0, 0, 4'hF, 4'hF, 0);
      checks++; if (m_if.rvalid !== 1'b0 || m_if.ready !== 1'b0 || m_if.rdata !== 32'h0) begin
         errors++; $display("FAIL rstmid_after: got rvalid=%b ready=%b rdata=%h expected 0/0/0", m_if.rvalid, m_if.ready, m_if.rdata); end
      advance();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         apply(1, i[0], 32'h8000_0000 | i, 0, 4'hF, 0, 0, 0);
         advance();
      end
      checks++; if (err_cnt !== 8'd255 || dec_err !== 1'b1) begin
         errors++; $display("FAIL sat_cnt: got cnt=%0d dec=%b expected 255/1", err_cnt, dec_err); end
      apply(1, 0, 32'hF000_0000, 0, 4'hF, 0, 0, 1);
      advance();
      checks++; if (err_cnt !== 8'd1 || dec_err !== 1'b1) begin
         errors++; $display("FAIL clr_vs_err: got cnt=%0d dec=%b expected 1/1", err_cnt, dec_err); end
   endtask

   task automatic test_random();
      bit v, wr, clr;
      logic [31:0] a, wd;
      logic [3:0] st, rdy, rv;
      for (int n = 0; n < 400; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         wr = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 4))
            0: a = $urandom & 32'h0000_FFFF;
            1: a = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
            2: a = 32'h4000_1000 | ($urandom & 32'h0000_0FFF);
            3: a = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
            default: a = $urandom;
         endcase
         wd = $urandom; st = 4'($urandom);
         rdy = 4'($urandom); rv = 4'($urandom);
         clr = ($urandom_range(0, 15) == 0);
         for (int k = 0; k < 4; k++) srd[k] = $urandom;
         apply(v, wr, a, wd, st, rdy, rv, clr);
         checks++; if (s_valid !== exp_svalid) begin errors++; $display("FAIL rnd_svalid[%0d]: got %b expected %b", n, s_valid, exp_svalid); end
         checks++; if (m_if.ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, m_if.ready, exp_ready); end
         checks++; if (m_if.rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", n, m_if.rvalid, exp_rvalid); end
         if (exp_rd_chk) begin
            checks++; if (m_if.rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, m_if.rdata, exp_rdata); end
         end
         checks++; if (s_addr !== a || s_wdata !== wd || s_wstrb !== st || s_write !== wr) begin
            errors++; $display("FAIL rnd_fwd[%0d]: got a=%h d=%h s=%h w=%b", n, s_addr, s_wdata, s_wstrb, s_write); end
         advance();
         checks++; if (err_cnt !== 8'(m_cnt) || dec_err !== m_dec || proto_err !== m_proto) begin
            errors++; $display("FAIL rnd_err[%0d]: got cnt=%0d dec=%b proto=%b expected %0d/%b/%b",
                               n, err_cnt, dec_err, proto_err, m_cnt, m_dec, m_proto); end
      end
   endtask

   initial begin
      rst = 1'b1; err_clr = 1'b0; s_ready = '0; s_rvalid = '0;
      m_if.valid = 1'b0; m_if.write = 1'b0; m_if.addr = '0; m_if.wdata = '0; m_if.wstrb = '0;
      for (int k = 0; k < 4; k++) srd[k] = '0;
      test_reset();
      test_write_s2();
      test_read_s0();
      test_overlap();
      test_unmapped();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
